ebus_device_responder: RTL and testbench
========================================

Name: ebus_device_responder

Overview:
- Device-side end of the EBUS I/O protocol that EDP drives.
- Decodes controller-select and function lines, runs the demand/transfer handshake, latches outbound EBUS data (CONO/DATAO) into device registers, and drives device data back onto EBUS for CONI/DATAI.
- Sits between the EBUS bundle and device-local logic; one instance per EBUS device.

Parameters:
- DEVICE_ID, 7'd4, controller-select code this instance answers to.
- XFER_DELAY, 2, EBOX clocks from demand detection to respXfer assertion (bus settle); legal range 1..15.
- CONO_MASK, 18'o777777, writable bits of the CONO register; unwritable bits hold reset value.

Ports:
- eboxClk  input  1  EBOX clock; all state on rising edge.
- eboxReset_n  input  1  asynchronous active-low reset.
- EBUS_CS  input  [0:6]  controller select from EBOX.
- EBUS_func  input  [0:2]  function: 000 CONI, 001 CONO, 010 DATAI, 011 DATAO; 1xx ignored.
- EBUS_demand  input  1  EBOX demand, level; held until respXfer seen.
- EBUS_in  input  [0:35]  EBUS data as driven by EBOX/EDP.
- devStatus  input  [0:17]  live device status for CONI right half.
- devDataIn  input  [0:35]  device word returned on DATAI.
- respEBUS  output  [0:35]  data this device drives; zero when not driving.
- respDrivingEBUS  output  1  this device owns EBUS data lines.
- respXfer  output  1  transfer acknowledge to EBOX.
- conReg  output  [0:17]  CONO register.
- dataOut  output  [0:35]  DATAO register.
- dataOutStrobe  output  1  one-clock pulse after dataOut updates.
- dataInAck  output  1  one-clock pulse when a DATAI completes.

Behaviour:
Reset (async, while eboxReset_n low): every output is 0; state IDLE; settle counter 0.

States:
- IDLE
  - Select condition: EBUS_demand=1, EBUS_CS==DEVICE_ID and EBUS_func[0]=0.
  - On select, capture func into an internal register, load counter with XFER_DELAY, go to SETTLE.
  - Input functions (CONI/DATAI) set respDrivingEBUS=1 on the same edge.
  - Any other demand is ignored; state remains IDLE.
- SETTLE
  - Counter decrements each clock. The transition is taken on the edge where the counter value is 1.
  - CONO: conReg <= (conReg & ~CONO_MASK) | (EBUS_in[18:35] & CONO_MASK).
  - DATAO: dataOut <= EBUS_in.
  - CONI: respEBUS = {18'b0, devStatus}.
  - DATAI: respEBUS = devDataIn, sampled each cycle.
  - On the exit edge respXfer <= 1 and the state goes to XFER.
  - First respXfer=1 is exactly XFER_DELAY clocks after the select edge.
- XFER
  - respXfer held at 1; respEBUS frozen at its last SETTLE value.
  - When EBUS_demand=0: respXfer <= 0, respDrivingEBUS <= 0, respEBUS <= 0, go to TURN.
  - dataOutStrobe pulses on the XFER-entry clock for DATAO only.
  - dataInAck pulses on the demand-drop clock for DATAI only.
- TURN
  - One idle clock for bus turnaround; selects are ignored; return to IDLE.
  - Back-to-back demand is answered no earlier than 2 clocks after the demand falls.

Boundary rules:
- Demand falls during SETTLE: abort to TURN, no register update, no strobe, no respXfer.
- CS or func changes during SETTLE/XFER: ignored; the latched func governs the transfer.
- Reset during any state returns to IDLE immediately; bus released, xfer dropped.
- respDrivingEBUS is never 1 for CONO/DATAO.
- conReg/dataOut change only in SETTLE on the exit edge.

Optional Feature:
- Macro EBUS_PARITY_EN.
- When defined, add ports:
  - EBUS_parity input 1, odd parity of EBUS_in.
  - respParity output 1, odd parity of respEBUS, valid while driving.
  - parityErr output 1, sticky, set on a CONO/DATAO latch edge if ^EBUS_in ^ EBUS_parity == 0.
- parityErr clears on reset or on a CONO with EBUS_in[18]=1.
- A bad-parity word is still latched.
- When undefined: the ports are absent and there is no parity logic.

Test Plan:
- DATAO, CS=4, EBUS_in=36'o123456_701234, demand held -> respXfer rises 2 clocks after select; dataOut=36'o123456701234; dataOutStrobe one pulse; respDrivingEBUS stays 0.
- CONO 36'o000000_777777 with CONO_MASK=18'o000777 from reset -> conReg=18'o000777. Then CONO 0 -> conReg=0.
- CONI, devStatus=18'o525252 -> while respXfer=1, respDrivingEBUS=1 and respEBUS=36'o000000525252. Demand drop -> all three are 0 next clock, then one TURN clock.
- DATAI, devDataIn=36'o777777000001 -> respEBUS matches, dataInAck pulses once at demand drop. Demand with CS=5 -> no response ever.
- Demand dropped 1 clock after select with XFER_DELAY=3 -> no respXfer, dataOut unchanged. Reset asserted mid-XFER -> all outputs 0 asynchronously.
- EBUS_PARITY_EN: DATAO 36'o1 with EBUS_parity=1 (even total) -> parityErr=1 and dataOut=1. CONO with bit 18 set -> parityErr=0.

Source files
------------

// File: rtl/ebus_device_responder.sv
// ebus_device_responder: device-side EBUS responder (select, settle, xfer, turnaround).
// Define EBUS_PARITY_EN to add odd-parity check on latched words and parity on driven data.
module ebus_device_responder #(
  parameter logic [0:6]  DEVICE_ID  = 7'd4,
  parameter int unsigned XFER_DELAY = 2,
  parameter logic [0:17] CONO_MASK  = 18'o777777
) (
  input  logic        eboxClk,
  input  logic        eboxReset_n,
  input  logic [0:6]  EBUS_CS,
  input  logic [0:2]  EBUS_func,
  input  logic        EBUS_demand,
  input  logic [0:35] EBUS_in,
  input  logic [0:17] devStatus,
  input  logic [0:35] devDataIn,
`ifdef EBUS_PARITY_EN
  input  logic        EBUS_parity,
  output logic        respParity,
  output logic        parityErr,
`endif
  output logic [0:35] respEBUS,
  output logic        respDrivingEBUS,
  output logic        respXfer,
  output logic [0:17] conReg,
  output logic [0:35] dataOut,
  output logic        dataOutStrobe,
  output logic        dataInAck
);
  typedef enum logic [1:0] {IDLE, SETTLE, XFER, TURN} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  fn_q, fn_d;
  logic [0:35] resp_q, resp_d;
  logic        drv_q, drv_d;
  logic        xfer_q, xfer_d;
  logic [0:17] con_q, con_d;
  logic [0:35] dout_q, dout_d;
  logic        strobe_q, strobe_d;
  logic        ack_q, ack_d;
  logic [0:35] dev_word;
`ifdef EBUS_PARITY_EN
  logic        perr_q, perr_d;
  assign respParity = drv_q & ~^resp_q;
  assign parityErr  = perr_q;
`endif
  // fn_q[1] selects DATA vs CON, fn_q[0] marks an outbound (write) function
  assign dev_word = fn_q[1] ? devDataIn : {18'b0, devStatus};
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fn_d     = fn_q;
    resp_d   = resp_q;
    drv_d    = drv_q;
    xfer_d   = xfer_q;
    con_d    = con_q;
    dout_d   = dout_q;
    strobe_d = 1'b0;
    ack_d    = 1'b0;
`ifdef EBUS_PARITY_EN
    perr_d   = perr_q;
`endif
    case (state_q)
      IDLE:
        if (EBUS_demand && EBUS_CS == DEVICE_ID && !EBUS_func[0]) begin
          fn_d    = EBUS_func[1:2];
          cnt_d   = 4'(XFER_DELAY);
          drv_d   = ~EBUS_func[2];
          state_d = SETTLE;
        end
      SETTLE:
        if (!EBUS_demand) begin
          cnt_d   = 4'd0;
          drv_d   = 1'b0;
          resp_d  = '0;
          state_d = TURN;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          resp_d = fn_q[0] ? resp_q : dev_word;
          if (cnt_q == 4'd1) begin
            xfer_d   = 1'b1;
            state_d  = XFER;
            con_d    = (fn_q == 2'b01) ? ((con_q & ~CONO_MASK) | (EBUS_in[18:35] & CONO_MASK)) : con_q;
            dout_d   = (fn_q == 2'b11) ? EBUS_in : dout_q;
            strobe_d = (fn_q == 2'b11);
`ifdef EBUS_PARITY_EN
            if (fn_q[0])
              perr_d = ~(^EBUS_in ^ EBUS_parity) | (perr_q & ~(!fn_q[1] && EBUS_in[18]));
`endif
          end
        end
      XFER:
        if (!EBUS_demand) begin
          xfer_d  = 1'b0;
          drv_d   = 1'b0;
          resp_d  = '0;
          ack_d   = (fn_q == 2'b10);
          state_d = TURN;
        end
      TURN: state_d = IDLE;
    endcase
  end
  always_ff @(posedge eboxClk or negedge eboxReset_n)
    if (!eboxReset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fn_q     <= '0;
      resp_q   <= '0;
      drv_q    <= 1'b0;
      xfer_q   <= 1'b0;
      con_q    <= '0;
      dout_q   <= '0;
      strobe_q <= 1'b0;
      ack_q    <= 1'b0;
`ifdef EBUS_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fn_q     <= fn_d;
      resp_q   <= resp_d;
      drv_q    <= drv_d;
      xfer_q   <= xfer_d;
      con_q    <= con_d;
      dout_q   <= dout_d;
      strobe_q <= strobe_d;
      ack_q    <= ack_d;
`ifdef EBUS_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  assign respEBUS        = resp_q;
  assign respDrivingEBUS = drv_q;
  assign respXfer        = xfer_q;
  assign conReg          = con_q;
  assign dataOut         = dout_q;
  assign dataOutStrobe   = strobe_q;
  assign dataInAck       = ack_q;
endmodule

// File: tb/tb_ebus_device_responder.sv
// tb_ebus_device_responder: directed checks of the EBUS responder handshake and registers.
module tb_ebus_device_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:6]  cs;
  logic [0:2]  func;
  logic        demand;
  logic [0:35] ebus_in;
  logic [0:17] dev_status;
  logic [0:35] dev_data;
  logic [0:35] resp;
  logic        drv, xfer, strobe, ack;
  logic [0:17] con;
  logic [0:35] dout;
`ifdef EBUS_PARITY_EN
  logic        par_in, par_out, perr;
`endif
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ebus_device_responder #(.DEVICE_ID(7'd4), .XFER_DELAY(2), .CONO_MASK(18'o000777)) dut (
    .eboxClk(clk), .eboxReset_n(rst_n), .EBUS_CS(cs), .EBUS_func(func),
    .EBUS_demand(demand), .EBUS_in(ebus_in), .devStatus(dev_status), .devDataIn(dev_data),
`ifdef EBUS_PARITY_EN
    .EBUS_parity(par_in), .respParity(par_out), .parityErr(perr),
`endif
    .respEBUS(resp), .respDrivingEBUS(drv), .respXfer(xfer), .conReg(con),
    .dataOut(dout), .dataOutStrobe(strobe), .dataInAck(ack));

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus(input logic d, input logic [0:6] c, input logic [0:2] f, input logic [0:35] w);
    demand = d; cs = c; func = f; ebus_in = w;
  endtask

  initial begin
    rst_n = 1'b0; dev_status = '0; dev_data = '0;
    bus(0, 0, 0, 0);
`ifdef EBUS_PARITY_EN
    par_in = 1'b0;
`endif
    cyc(2);
    chk("rst_resp", 36'(resp), 0);
    chk("rst_ctl", {drv, xfer, strobe, ack}, 0);
    chk("rst_regs", 36'({con, dout}), 0);
    rst_n = 1'b1;
    cyc(1);
    // DATAO: respXfer two clocks after select, strobe for one clock
    bus(1, 4, 3'b011, 36'o123456701234);
    cyc(1);
    chk("datao_sel_xfer", xfer, 0);
    cyc(1);
    chk("datao_early_xfer", xfer, 0);
    chk("datao_early_dout", 36'(dout), 0);
    cyc(1);
    chk("datao_xfer", xfer, 1);
    chk("datao_dout", 36'(dout), 36'o123456701234);
    chk("datao_strobe", strobe, 1);
    chk("datao_drv", drv, 0);
    cyc(1);
    chk("datao_strobe_end", strobe, 0);
    chk("datao_xfer_hold", xfer, 1);
    demand = 0;
    cyc(1);
    chk("datao_xfer_drop", xfer, 0);
    cyc(1);
    // CONO through mask 000777
    bus(1, 4, 3'b001, 36'o000000777777);
    cyc(3);
    chk("cono_con", 36'(con), 36'o000777);
    chk("cono_drv", drv, 0);
    demand = 0;
    cyc(2);
    bus(1, 4, 3'b001, 0);
    cyc(3);
    chk("cono_zero", 36'(con), 0);
    demand = 0;
    cyc(2);
    // CONI: drives status, frozen during XFER
    dev_status = 18'o525252;
    bus(1, 4, 3'b000, 0);
    cyc(1);
    chk("coni_drv_sel", drv, 1);
    cyc(2);
    chk("coni_xfer", xfer, 1);
    chk("coni_drv", drv, 1);
    chk("coni_resp", 36'(resp), 36'o000000525252);
    dev_status = 18'o111111;
    cyc(1);
    chk("coni_frozen", 36'(resp), 36'o000000525252);
    demand = 0;
    cyc(1);
    chk("coni_drop", {xfer, drv}, 0);
    chk("coni_drop_resp", 36'(resp), 0);
    // back-to-back DATAI raised during TURN
    dev_data = 36'o777777000001;
    bus(1, 4, 3'b010, 0);
    cyc(1);
    chk("turn_ignored", drv, 0);
    cyc(1);
    chk("datai_drv_sel", drv, 1);
    cyc(2);
    chk("datai_xfer", xfer, 1);
    chk("datai_resp", 36'(resp), 36'o777777000001);
    chk("datai_ack_early", ack, 0);
    demand = 0;
    cyc(1);
    chk("datai_ack", ack, 1);
    chk("datai_drop_resp", 36'(resp), 0);
    cyc(1);
    chk("datai_ack_end", ack, 0);
    // wrong CS and 1xx functions are ignored
    bus(1, 5, 3'b011, 36'o7);
    cyc(6);
    chk("cs5_ctl", {xfer, drv}, 0);
    chk("cs5_dout", 36'(dout), 36'o123456701234);
    bus(1, 4, 3'b111, 36'o7);
    cyc(4);
    chk("func1xx_ctl", {xfer, drv}, 0);
    demand = 0;
    cyc(1);
    // demand dropped during SETTLE aborts
    bus(1, 4, 3'b011, 36'o55);
    cyc(1);
    demand = 0;
    cyc(1);
    chk("abort_xfer", xfer, 0);
    chk("abort_strobe", strobe, 0);
    cyc(3);
    chk("abort_xfer_late", xfer, 0);
    chk("abort_dout", 36'(dout), 36'o123456701234);
    // CS/func changes after select do not affect the latched function
    bus(1, 4, 3'b011, 36'o42);
    cyc(1);
    cs = 5; func = 3'b000;
    cyc(2);
    chk("latch_xfer", xfer, 1);
    chk("latch_dout", 36'(dout), 36'o42);
    chk("latch_drv", drv, 0);
    demand = 0;
    cyc(2);
    // async reset mid-XFER
    bus(1, 4, 3'b000, 0);
    cyc(3);
    chk("pre_rst_xfer", xfer, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", {xfer, drv}, 0);
    chk("async_rst_resp", 36'(resp), 0);
    chk("async_rst_dout", 36'(dout), 0);
    demand = 0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
`ifdef EBUS_PARITY_EN
    bus(1, 4, 3'b011, 36'o1);
    par_in = 1'b1;
    cyc(3);
    chk("par_err_set", perr, 1);
    chk("par_dout", 36'(dout), 36'o1);
    demand = 0;
    cyc(2);
    bus(1, 4, 3'b001, 36'o000000400000);
    par_in = 1'b0;
    cyc(3);
    chk("par_err_clr", perr, 0);
    demand = 0;
    cyc(2);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
